multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle MIPS datapath: a Moore-style FSM that sequences each instruction through fetch, decode, execute, memory and writeback, replacing the single-cycle decoder for the shared-memory datapath. It adds memory-ready stalling, an illegal-instruction flag and a visible state register. It supports R-type (add/sub/and/or/slt), lw, sw, beq, bne, addi, ori and j, and drives all datapath muxes and enables each cycle.

## Interface
- ALUCTL_W, 3: ALU control width; codes occupy the low 3 bits, upper bits are 0.
- HANDSHAKE, 1: 1 = FETCH/MEMRD/MEMWR wait for memready; 0 = memready ignored (treated as 1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction opcode from the instruction register.
- funct  in  6  instruction funct field.
- zero  in  1  ALU zero flag.
- memready  in  1  memory access completes this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write enable.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register: 0 = rt, 1 = rd.
- memtoreg  out  1  writeback data: 0 = ALUOut, 1 = Data.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A: 0 = PC, 1 = A register.
- alusrcb  out  2  ALU B: 00 = B, 01 = 4, 10 = immext, 11 = immext<<2.
- pcsrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC load enable, branch condition already folded in.
- ori  out  1  zero-extend immediate.
- alucontrol  out  ALUCTL_W  ALU operation.
- illegal  out  1  one-cycle pulse on unsupported op/funct.
- state  out  4  current FSM state.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, BNEEX 12, ORIEX 13. Codes 14–15 go to FETCH on the next edge.
- All outputs default to 0 and alucontrol defaults to 010 (add). Only the deviations below are asserted.
- FETCH: alusrcb=01. irwrite=pcen=memready. Advance to DECODE on memready; otherwise hold.
- DECODE: alusrcb=11. Next state by op:
  - 100011 or 101011 → MEMADR
  - 000000 → RTYPEEX
  - 000100 → BEQEX
  - 000101 → BNEEX
  - 001000 → ADDIEX
  - 001101 → ORIEX
  - 000010 → JEX
  - any other op: illegal=1 and → FETCH.
- MEMADR: alusrca=1, alusrcb=10. op 100011 → MEMRD, else → MEMWR.
- MEMRD: iord=1. Hold until memready, then → MEMWB.
- MEMWB: memtoreg=1, regwrite=1 → FETCH.
- MEMWR: iord=1, memwrite=1, held until memready, then → FETCH.
- RTYPEEX: alusrca=1, alusrcb=00. alucontrol by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Known funct → RTYPEWB. Unknown funct: illegal=1, alucontrol=010, → FETCH with no writeback.
- RTYPEWB: regdst=1, regwrite=1 → FETCH.
- BEQEX: alusrca=1, alucontrol=110, pcsrc=01, pcen=zero → FETCH.
- BNEEX: as BEQEX but pcen=~zero → FETCH.
- ADDIEX: alusrca=1, alusrcb=10 → IMMWB.
- ORIEX: alusrca=1, alusrcb=10, alucontrol=001, ori=1 → IMMWB.
- IMMWB: regwrite=1 → FETCH.
- JEX: pcsrc=10, pcen=1 → FETCH.

## Timing
- State register updates on rising clk. All outputs are combinational from state, plus op/funct/zero/memready where listed.
- Reset: the state becomes FETCH on the first edge with reset=1. While reset=1, pcen, irwrite, regwrite, memwrite and illegal are forced to 0 regardless of state.
- Reset mid-instruction aborts it; no write enables fire in the reset cycle. The first cycle after reset deasserts is FETCH.
- op/funct must be stable from DECODE until return to FETCH (they come from the IR, loaded only in FETCH).
- Latency with memready tied to 1: lw 5 cycles; sw, R-type, addi and ori 4; beq, bne and j 3; illegal op 2.
- Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held constant during the stall.
- HANDSHAKE=0: stall states never hold.
- illegal is high exactly one cycle per offending instruction.

## Test plan
- Reset: hold reset 2 cycles while in an arbitrary state → state=0 and all write enables 0 throughout. Release → FETCH asserts irwrite=pcen=1.
- lw (op 100011), memready=1 → state sequence 0,1,2,3,4,0. MEMWB shows regwrite=1, memtoreg=1, regdst=0.
- sw with memready low for 3 cycles in MEMWR → state 5 held 4 cycles with memwrite=iord=1, then FETCH. Total 7 cycles.
- beq with zero=1 and bne with zero=1 → pcen=1 in BEQEX, pcen=0 in BNEEX. Both show pcsrc=01 and alucontrol=110.
- R-type: funct 101010 → alucontrol=111, then RTYPEWB with regdst=1. funct 000111 → illegal pulse in RTYPEEX, regwrite never asserted.
- Unknown op 111111 → illegal=1 in DECODE, back to FETCH next cycle. ori (001101) → ori=1, alucontrol=001, then IMMWB regwrite=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the shared-memory multicycle
// MIPS datapath. Steps every instruction through fetch/decode/execute/memory/
// writeback, stalls on memready, flags unsupported op/funct with a one-cycle
// illegal pulse and exposes the current state on the state port.
//
// Handshake: memready is the memory's completion strobe. In FETCH, MEMRD and
// MEMWR the access is considered done in the cycle memready=1 and the FSM
// advances on the following edge. While memready=0 the state and every output
// hold steady. With HANDSHAKE=0 memready is ignored and treated as always 1.
module multicycle_controller #(
  parameter int ALUCTL_W  = 3,
  parameter bit HANDSHAKE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                memready,
  output logic                iord,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                pcen,
  output logic                ori,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                illegal,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    IMMWB   = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12,
    ORIEX   = 4'd13
  } state_t;

  state_t state_q, state_d;

  // Effective memory completion; without the handshake stall states never hold.
  logic mem_ok;
  assign mem_ok = HANDSHAKE ? memready : 1'b1;

  // Write enables before the reset override.
  logic pcen_c, irwrite_c, regwrite_c, memwrite_c, illegal_c;
  logic [2:0] alu3;

  // State register; reset lands in FETCH on the first edge it is seen.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; everything defaults to 0 with ALU = add.
  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen_c     = 1'b0;
    ori        = 1'b0;
    alu3       = 3'b010;
    illegal_c  = 1'b0;
    case (state_q)
      FETCH: begin
        alusrcb   = 2'b01;
        irwrite_c = mem_ok;
        pcen_c    = mem_ok;
        state_d   = mem_ok ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = RTYPEEX;
          6'b000100:            state_d = BEQEX;
          6'b000101:            state_d = BNEEX;
          6'b001000:            state_d = ADDIEX;
          6'b001101:            state_d = ORIEX;
          6'b000010:            state_d = JEX;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = mem_ok ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
        state_d    = mem_ok ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        state_d = RTYPEWB;
        case (funct)
          6'b100000: alu3 = 3'b010;
          6'b100010: alu3 = 3'b110;
          6'b100100: alu3 = 3'b000;
          6'b100101: alu3 = 3'b001;
          6'b101010: alu3 = 3'b111;
          default: begin
            illegal_c = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca = 1'b1;
        alu3    = 3'b110;
        pcsrc   = 2'b01;
        pcen_c  = (state_q == BEQEX) ? zero : ~zero;
        state_d = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = IMMWB;
      end
      ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu3    = 3'b001;
        ori     = 1'b1;
        state_d = IMMWB;
      end
      IMMWB: begin
        regwrite_c = 1'b1;
        state_d    = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcen_c  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset suppresses every enable so an aborted instruction commits nothing.
  assign pcen       = pcen_c     & ~reset;
  assign irwrite    = irwrite_c  & ~reset;
  assign regwrite   = regwrite_c & ~reset;
  assign memwrite   = memwrite_c & ~reset;
  assign illegal    = illegal_c  & ~reset;
  assign alucontrol = ALUCTL_W'(alu3);
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction reference sequences (one expected
// output vector per cycle) pushed into a queue by the driver and checked by an
// independent negedge monitor.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, ori, illegal;
  logic [2:0] alucontrol;
  logic [3:0] state;

  multicycle_controller #(.ALUCTL_W(3), .HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memready(memready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen),
    .ori(ori), .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, ori;
    logic [2:0] aluc;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [5:0] op, funct;
    logic       mr, z;
    exp_t       e;
  } step_t;

  logic [20:0] exp_q[$];
  step_t       plan[$];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.aluc = 3'b010;
    return e;
  endfunction

  function automatic logic pick_z(input int zsel);
    if (zsel == 2) return 1'($urandom_range(0, 1));
    return zsel[0];
  endfunction

  task automatic add(input logic [5:0] o, input logic [5:0] f,
                     input logic mr, input logic z, input exp_t e);
    step_t s;
    s.op = o; s.funct = f; s.mr = mr; s.z = z; s.e = e;
    plan.push_back(s);
  endtask

  // Reference: the cycle-by-cycle output sequence of one instruction.
  // fs/ms = memready-low cycles in fetch / memory access.
  task automatic build(input logic [5:0] o, input logic [5:0] f,
                       input int fs, input int ms, input int zsel);
    exp_t e;
    logic mr, z, known;
    logic [2:0] ac;
    plan.delete();
    for (int k = 0; k <= fs; k++) begin
      mr = (k == fs);
      e = base(4'd0); e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr;
      add(o, f, mr, pick_z(2), e);
    end
    known = (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                       6'b000101, 6'b001000, 6'b001101, 6'b000010});
    e = base(4'd1); e.alusrcb = 2'b11; e.illegal = ~known;
    add(o, f, pick_z(2), pick_z(2), e);
    if (!known) return;
    case (o)
      6'b100011, 6'b101011: begin
        e = base(4'd2); e.alusrca = 1; e.alusrcb = 2'b10;
        add(o, f, pick_z(2), pick_z(2), e);
        for (int k = 0; k <= ms; k++) begin
          mr = (k == ms);
          if (o == 6'b100011) begin
            e = base(4'd3); e.iord = 1;
          end else begin
            e = base(4'd5); e.iord = 1; e.memwrite = 1;
          end
          add(o, f, mr, pick_z(2), e);
        end
        if (o == 6'b100011) begin
          e = base(4'd4); e.memtoreg = 1; e.regwrite = 1;
          add(o, f, pick_z(2), pick_z(2), e);
        end
      end
      6'b000000: begin
        known = 1'b1;
        case (f)
          6'b100000: ac = 3'b010;
          6'b100010: ac = 3'b110;
          6'b100100: ac = 3'b000;
          6'b100101: ac = 3'b001;
          6'b101010: ac = 3'b111;
          default: begin ac = 3'b010; known = 1'b0; end
        endcase
        e = base(4'd6); e.alusrca = 1; e.aluc = ac; e.illegal = ~known;
        add(o, f, pick_z(2), pick_z(2), e);
        if (known) begin
          e = base(4'd7); e.regdst = 1; e.regwrite = 1;
          add(o, f, pick_z(2), pick_z(2), e);
        end
      end
      6'b000100, 6'b000101: begin
        z = pick_z(zsel);
        e = base((o == 6'b000100) ? 4'd8 : 4'd12);
        e.alusrca = 1; e.aluc = 3'b110; e.pcsrc = 2'b01;
        e.pcen = (o == 6'b000100) ? z : ~z;
        add(o, f, pick_z(2), z, e);
      end
      6'b001000, 6'b001101: begin
        e = base((o == 6'b001000) ? 4'd9 : 4'd13);
        e.alusrca = 1; e.alusrcb = 2'b10;
        if (o == 6'b001101) begin e.aluc = 3'b001; e.ori = 1; end
        add(o, f, pick_z(2), pick_z(2), e);
        e = base(4'd10); e.regwrite = 1;
        add(o, f, pick_z(2), pick_z(2), e);
      end
      default: begin
        e = base(4'd11); e.pcsrc = 2'b10; e.pcen = 1;
        add(o, f, pick_z(2), pick_z(2), e);
      end
    endcase
  endtask

  // Driver tasks
  task automatic apply_step(input step_t s, input logic rst);
    @(posedge clk);
    #1;
    reset = rst; op = s.op; funct = s.funct; memready = s.mr; zero = s.z;
    exp_q.push_back(s.e);
  endtask

  // A reset cycle seen from FETCH: only the fetch mux settings remain.
  task automatic reset_cycle();
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b1; memready = 1'($urandom_range(0, 1));
    e = base(4'd0); e.alusrcb = 2'b01;
    exp_q.push_back(e);
  endtask

  // Run the current plan; abort_at >= 0 asserts reset for two cycles there.
  task automatic run_plan(input int abort_at);
    step_t s;
    for (int i = 0; i < plan.size(); i++) begin
      s = plan[i];
      if (i == abort_at) begin
        s.e.irwrite = 0; s.e.pcen = 0; s.e.regwrite = 0;
        s.e.memwrite = 0; s.e.illegal = 0;
        apply_step(s, 1'b1);
        reset_cycle();
        return;
      end
      apply_step(s, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int fs, input int ms, input int zsel);
    build(o, f, fs, ms, zsel);
    run_plan(-1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [20:0] got, exp;
    if (exp_q.size() > 0) begin
      got = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, pcen, ori, alucontrol, illegal};
      exp = exp_q.pop_front();
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL outputs @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                 $time, got[20:17], got, exp[20:17], exp);
      end
    end
  end

  logic [5:0] op_tab[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                            6'b000101, 6'b001000, 6'b001101, 6'b000010};
  logic [5:0] fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] o, f;
    int wait_cnt;
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; memready = 1'b1;
    @(posedge clk);
    reset_cycle();
    reset_cycle();

    // Directed
    run_instr(6'b100011, 6'b000000, 0, 0, 2);   // lw
    run_instr(6'b101011, 6'b000000, 0, 3, 2);   // sw, MEMWR stall 3
    run_instr(6'b000100, 6'b000000, 0, 0, 1);   // beq zero=1
    run_instr(6'b000101, 6'b000000, 0, 0, 1);   // bne zero=1
    run_instr(6'b000000, 6'b101010, 0, 0, 2);   // slt
    run_instr(6'b000000, 6'b000111, 0, 0, 2);   // bad funct
    run_instr(6'b111111, 6'b000000, 0, 0, 2);   // bad op
    run_instr(6'b001101, 6'b000000, 0, 0, 2);   // ori
    run_instr(6'b100011, 6'b000000, 2, 2, 2);   // lw with stalls
    build(6'b100011, 6'b000000, 0, 1, 2);       // reset mid lw
    run_plan(3);

    // Random
    for (int n = 0; n < 150; n++) begin
      int idx;
      idx = $urandom_range(0, 9);
      o = (idx < 8) ? op_tab[idx] : 6'($urandom_range(0, 63));
      f = ($urandom_range(0, 9) < 7) ? fn_tab[$urandom_range(0, 4)]
                                     : 6'($urandom_range(0, 63));
      build(o, f, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
            $urandom_range(0, 3), 2);
      if (n % 25 == 7) run_plan($urandom_range(0, plan.size() - 1));
      else             run_plan(-1);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
